trace_cmd_dispatch: RTL and testbench

//  Sits between the trace-file reader and the cache model. Buffers parsed trace records
//  (command, 32-bit address) in a FIFO, splits each address into tag/index/byte-select,
//  and issues one request per cycle to the cache over a valid/ready handshake.

---
 rtl/trace_cmd_dispatch_if.sv | 31 +++
 rtl/trace_cmd_dispatch.sv | 120 ++++++++++++
 tb/tb_trace_cmd_dispatch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/trace_cmd_dispatch_if.sv
// Trace-record input and cache-request output handshakes of trace_cmd_dispatch.
// The dispatcher takes the slave view; the reader/cache side takes the master view.
interface trace_cmd_dispatch_if #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;

  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_cmd;
  logic [ADDR_W-1:0]      in_addr;

  logic                   req_valid;
  logic                   req_ready;
  logic [3:0]             req_cmd;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_offset;

  modport slave (
    input  in_valid, in_cmd, in_addr, req_ready,
    output in_ready, req_valid, req_cmd, req_tag, req_index, req_offset
  );

  modport master (
    output in_valid, in_cmd, in_addr, req_ready,
    input  in_ready, req_valid, req_cmd, req_tag, req_index, req_offset
  );
endinterface

// File: rtl/trace_cmd_dispatch.sv
// Buffers trace records, issues one cache request per cycle, expands clear/print
// commands into per-set sweeps and keeps saturating per-command statistics.
module trace_cmd_dispatch #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  trace_cmd_dispatch_if.slave   bus,
  output logic                  sweep_valid,
  output logic                  sweep_clear,
  output logic [INDEX_BITS-1:0] sweep_index,
  output logic                  busy,
  output logic                  illegal_cmd,
  output logic [CNT_W-1:0]      cnt_read,
  output logic [CNT_W-1:0]      cnt_write,
  output logic [CNT_W-1:0]      cnt_ifetch,
  output logic [CNT_W-1:0]      cnt_snoop
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int REC_W    = 4 + ADDR_W;

  typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_e;

  logic [REC_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q [4];
  logic [CNT_W-1:0]      cnt_d [4];

  logic                  empty, full, push, pop;
  logic                  head_live, head_is_req, req_fire;
  logic [3:0]            head_cmd;
  logic [ADDR_W-1:0]     head_addr;
  logic [1:0]            cnt_sel;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = bus.in_valid && !full;

  assign {head_cmd, head_addr} = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_live   = (state_q == IDLE) && !empty;
  assign head_is_req = (head_cmd <= 4'd4);
  assign req_fire    = head_live && head_is_req && bus.req_ready;
  // Non-request records (maintenance or illegal) leave the FIFO without a handshake.
  assign pop         = req_fire || (head_live && !head_is_req);
  // cmd 3 and 4 share the snoop counter.
  assign cnt_sel     = (head_cmd > 4'd2) ? 2'd3 : head_cmd[1:0];

  // Request fields are gated so stale FIFO storage never shows while idle.
  assign bus.in_ready   = !full;
  assign bus.req_valid  = head_live && head_is_req;
  assign bus.req_cmd    = bus.req_valid ? head_cmd : '0;
  assign bus.req_tag    = bus.req_valid ? head_addr[ADDR_W-1 -: TAG_BITS] : '0;
  assign bus.req_index  = bus.req_valid ? head_addr[OFFSET_BITS +: INDEX_BITS] : '0;
  assign bus.req_offset = bus.req_valid ? head_addr[OFFSET_BITS-1:0] : '0;

  assign illegal_cmd = head_live && !head_is_req && (head_cmd != 4'd8) && (head_cmd != 4'd9);
  assign sweep_valid = (state_q != IDLE);
  assign sweep_clear = (state_q == CLEAR);
  assign sweep_index = idx_q;
  assign busy        = !empty || (state_q != IDLE);

  assign cnt_read   = cnt_q[0];
  assign cnt_write  = cnt_q[1];
  assign cnt_ifetch = cnt_q[2];
  assign cnt_snoop  = cnt_q[3];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (head_live && head_cmd == 4'd8)      state_d = CLEAR;
        else if (head_live && head_cmd == 4'd9) state_d = DUMP;
      end
      default: begin
        if (idx_q == '1) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (state_q == CLEAR && idx_q == '0) begin
          for (int unsigned k = 0; k < 4; k++) cnt_d[k] = '0;
        end
      end
    endcase
    if (req_fire && cnt_q[cnt_sel] != '1) cnt_d[cnt_sel] = cnt_q[cnt_sel] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.in_cmd, bus.in_addr};
  end
endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// Bench for trace_cmd_dispatch: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the dispatcher.
module tb_trace_cmd_dispatch;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 14;
  localparam int FIFO_DEPTH  = 8;
  localparam int CNT_W       = 4;
  localparam int unsigned MAX_IDX  = (1 << INDEX_BITS) - 1;
  localparam int unsigned OFF_MASK = (1 << OFFSET_BITS) - 1;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  sweep_valid, sweep_clear, busy, illegal_cmd;
  logic [INDEX_BITS-1:0] sweep_index;
  logic [CNT_W-1:0]      cnt_read, cnt_write, cnt_ifetch, cnt_snoop;

  trace_cmd_dispatch_if #(.ADDR_W(ADDR_W), .OFFSET_BITS(OFFSET_BITS),
                          .INDEX_BITS(INDEX_BITS)) bus ();

  trace_cmd_dispatch #(
    .ADDR_W(ADDR_W), .OFFSET_BITS(OFFSET_BITS), .INDEX_BITS(INDEX_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sweep_valid(sweep_valid), .sweep_clear(sweep_clear), .sweep_index(sweep_index),
    .busy(busy), .illegal_cmd(illegal_cmd),
    .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_ifetch(cnt_ifetch), .cnt_snoop(cnt_snoop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending records, sweep mode (0 none, 1 clear, 2 print), sweep position, counters.
  logic [3:0]  m_cmd[$];
  logic [31:0] m_addr[$];
  int unsigned m_mode, m_pos;
  int unsigned m_cnt[4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd.delete();
    m_addr.delete();
    m_mode = 0;
    m_pos  = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
  endtask

  task automatic compare_all();
    bit          has, exp_req, exp_ill;
    logic [3:0]  hc;
    logic [31:0] ha;
    has = (m_mode == 0) && (m_cmd.size() > 0);
    hc = 4'd0;
    ha = 32'd0;
    if (has) begin
      hc = m_cmd[0];
      ha = m_addr[0];
    end
    exp_req = has && (hc <= 4'd4);
    exp_ill = has && !(hc <= 4'd4 || hc == 4'd8 || hc == 4'd9);
    check_eq("in_ready",    64'(bus.in_ready),  64'(m_cmd.size() < FIFO_DEPTH));
    check_eq("busy",        64'(busy),          64'(m_cmd.size() > 0 || m_mode != 0));
    check_eq("req_valid",   64'(bus.req_valid), 64'(exp_req));
    check_eq("illegal_cmd", 64'(illegal_cmd),   64'(exp_ill));
    check_eq("sweep_valid", 64'(sweep_valid),   64'(m_mode != 0));
    check_eq("sweep_clear", 64'(sweep_clear),   64'(m_mode == 1));
    check_eq("sweep_index", 64'(sweep_index),   64'(m_pos));
    if (exp_req) begin
      check_eq("req_cmd",    64'(bus.req_cmd),    64'(hc));
      check_eq("req_tag",    64'(bus.req_tag),    64'(ha >> (OFFSET_BITS + INDEX_BITS)));
      check_eq("req_index",  64'(bus.req_index),  64'((ha >> OFFSET_BITS) & MAX_IDX));
      check_eq("req_offset", 64'(bus.req_offset), 64'(ha & OFF_MASK));
    end
    check_eq("cnt_read",   64'(cnt_read),   64'(m_cnt[0]));
    check_eq("cnt_write",  64'(cnt_write),  64'(m_cnt[1]));
    check_eq("cnt_ifetch", 64'(cnt_ifetch), 64'(m_cnt[2]));
    check_eq("cnt_snoop",  64'(cnt_snoop),  64'(m_cnt[3]));
  endtask

  task automatic model_advance(input bit iv, input logic [3:0] ic, input logic [31:0] ia,
                               input bit rr);
    bit do_pop, do_push;
    int unsigned c;
    do_pop  = 1'b0;
    do_push = iv && (m_cmd.size() < FIFO_DEPTH);
    if (m_mode != 0) begin
      if (m_mode == 1 && m_pos == 0) foreach (m_cnt[k]) m_cnt[k] = 0;
      if (m_pos == MAX_IDX) begin
        m_mode = 0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end else if (m_cmd.size() > 0) begin
      if (m_cmd[0] <= 4'd4) begin
        if (rr) begin
          do_pop = 1'b1;
          c = (m_cmd[0] >= 4'd3) ? 3 : int'(m_cmd[0]);
          if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
        end
      end else begin
        do_pop = 1'b1;
        if (m_cmd[0] == 4'd8)      m_mode = 1;
        else if (m_cmd[0] == 4'd9) m_mode = 2;
        m_pos = 0;
      end
    end
    if (do_pop) begin
      void'(m_cmd.pop_front());
      void'(m_addr.pop_front());
    end
    if (do_push) begin
      m_cmd.push_back(ic);
      m_addr.push_back(ia);
    end
  endtask

  // Called at a falling edge: compare, drive the next inputs, advance the model one cycle.
  task automatic step(input bit iv, input logic [3:0] ic, input logic [31:0] ia, input bit rr);
    compare_all();
    bus.in_valid  = iv;
    bus.in_cmd    = ic;
    bus.in_addr   = ia;
    bus.req_ready = rr;
    model_advance(iv, ic, ia, rr);
    @(negedge clk);
  endtask

  initial begin
    int unsigned r, sweeps_left;
    logic [3:0]  c;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.in_addr = '0; bus.req_ready = 1'b0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single read: address split and counter after handshake.
    step(1'b1, 4'd0, 32'h0000_1040, 1'b1);
    check_eq("t1_req_valid", 64'(bus.req_valid), 64'd1);
    check_eq("t1_tag",       64'(bus.req_tag),   64'd0);
    check_eq("t1_index",     64'(bus.req_index), 64'h41);
    check_eq("t1_offset",    64'(bus.req_offset), 64'd0);
    step(1'b0, 4'd0, 32'd0, 1'b1);
    check_eq("t1_cnt_read",  64'(cnt_read), 64'd1);

    // Fill past capacity with the cache stalled, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i % 5), $urandom, 1'b0);
    check_eq("t2_full_in_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 4'd1, $urandom, 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b1);
    check_eq("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 32'd0, 1'b1);

    // Clear sweep followed by an all-ones write address.
    step(1'b1, 4'd8, $urandom, 1'b1);
    step(1'b1, 4'd1, 32'hFFFF_FFFF, 1'b1);
    for (int unsigned i = 0; i < MAX_IDX + 5; i++) step(1'b0, 4'd0, 32'd0, 1'b1);
    check_eq("t3_cnt_write", 64'(cnt_write), 64'd1);
    check_eq("t3_cnt_read",  64'(cnt_read),  64'd0);

    // Illegal command.
    step(1'b1, 4'd6, $urandom, 1'b1);
    check_eq("t4_illegal", 64'(illegal_cmd), 64'd1);
    step(1'b0, 4'd0, 32'd0, 1'b1);
    check_eq("t4_illegal_off", 64'(illegal_cmd), 64'd0);
    step(1'b0, 4'd0, 32'd0, 1'b1);

    // Counter saturation.
    for (int i = 0; i < 20; i++) step(1'b1, 4'd0, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 1'b1);
    check_eq("t6_cnt_sat", 64'(cnt_read), 64'(CNT_MAX));

    // Reset in the middle of a print sweep with queued records.
    step(1'b1, 4'd9, $urandom, 1'b1);
    for (int i = 0; i < 300 && !(m_mode != 0 && m_pos == 100); i++)
      step(1'b1, 4'd0, $urandom, 1'b1);
    check_eq("t5_at_100", 64'(sweep_index), 64'd100);
    compare_all();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.req_ready = 1'b0;
    #1;
    model_reset();
    check_eq("t5_sweep_valid", 64'(sweep_valid), 64'd0);
    check_eq("t5_busy",        64'(busy),        64'd0);
    check_eq("t5_in_ready",    64'(bus.in_ready), 64'd1);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, at most one sweep.
    sweeps_left = 1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80) begin
        c = 4'($urandom_range(0, 4));
      end else if (r < 97) begin
        c = 4'($urandom_range(5, 15));
        if (c == 4'd8 || c == 4'd9) c = 4'd7;
      end else if (sweeps_left > 0) begin
        c = ($urandom_range(0, 1) == 1) ? 4'd8 : 4'd9;
        sweeps_left--;
      end else begin
        c = 4'd2;
      end
      step($urandom_range(0, 9) < 6, c, $urandom, $urandom_range(0, 9) < 7);
    end
    for (int unsigned i = 0; i < MAX_IDX + 40 && (m_mode != 0 || m_cmd.size() > 0); i++)
      step(1'b0, 4'd0, 32'd0, 1'b1);
    compare_all();
    check_eq("drained_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
